// File: rtl/ucaspian_mc_router.sv
// rtl/ucaspian_mc_router.sv - host byte stream to per-core packet router with round-robin TX merge
module ucaspian_mc_router #(
    parameter int NUM_CORES = 4
) (
    input  logic                   sys_clk,
    input  logic                   reset,
    input  logic [7:0]             read_data,
    input  logic                   read_vld,
    output logic                   read_rdy,
    output logic [7:0]             write_data,
    output logic                   write_vld,
    input  logic                   write_rdy,
    output logic [8*NUM_CORES-1:0] core_rx_data,
    output logic [NUM_CORES-1:0]   core_rx_vld,
    input  logic [NUM_CORES-1:0]   core_rx_rdy,
    input  logic [8*NUM_CORES-1:0] core_tx_data,
    input  logic [NUM_CORES-1:0]   core_tx_vld,
    input  logic [NUM_CORES-1:0]   core_tx_last,
    output logic [NUM_CORES-1:0]   core_tx_rdy,
    output logic [7:0]             drop_count,
    output logic                   led_busy
);
    typedef enum logic [1:0] {R_HDR, R_LEN, R_PAY, R_DROP} rx_state_t;
    typedef enum logic [1:0] {T_IDLE, T_HDR, T_BODY} tx_state_t;

    localparam logic [4:0] NC        = 5'(NUM_CORES);
    localparam logic [3:0] LAST_CORE = 4'(NUM_CORES - 1);

    rx_state_t rx_state_q, rx_state_d;
    logic [3:0] sel_q, sel_d;
    logic [7:0] remain_q, remain_d;
    logic [7:0] drop_count_q, drop_count_d;

    tx_state_t tx_state_q, tx_state_d;
    logic [3:0] grant_q, grant_d;
    logic [3:0] last_grant_q, last_grant_d;

    logic                 rx_rdy, sel_rdy;
    logic [NUM_CORES-1:0] rx_vld;
    logic                 wr_vld;
    logic [7:0]           wr_data;
    logic [NUM_CORES-1:0] tx_rdy;
    logic [7:0]           body_data;
    logic                 body_vld, body_last;
    logic [4:0]           cand;
    logic [3:0]           pick;
    logic                 pick_vld;

    always_comb begin
        rx_state_d   = rx_state_q;
        sel_d        = sel_q;
        remain_d     = remain_q;
        drop_count_d = drop_count_q;
        rx_rdy       = 1'b0;
        rx_vld       = '0;
        sel_rdy      = 1'b0;
        for (int i = 0; i < NUM_CORES; i++)
            if (sel_q == 4'(i)) sel_rdy = core_rx_rdy[i];
        case (rx_state_q)
            R_HDR: begin
                rx_rdy = 1'b1;
                if (read_vld) begin
                    sel_d      = read_data[3:0];
                    rx_state_d = R_LEN;
                end
            end
            R_LEN: begin
                rx_rdy = 1'b1;
                if (read_vld) begin
                    remain_d = read_data;
                    if (read_data == 8'd0) begin
                        rx_state_d = R_HDR;
                    end else if ({1'b0, sel_q} >= NC) begin
                        rx_state_d = R_DROP;
                        if (drop_count_q != 8'hFF) drop_count_d = drop_count_q + 8'd1;
                    end else begin
                        rx_state_d = R_PAY;
                    end
                end
            end
            R_PAY: begin
                rx_rdy = sel_rdy;
                for (int i = 0; i < NUM_CORES; i++)
                    rx_vld[i] = read_vld && (sel_q == 4'(i));
                if (read_vld && sel_rdy) begin
                    remain_d = remain_q - 8'd1;
                    if (remain_q == 8'd1) rx_state_d = R_HDR;
                end
            end
            R_DROP: begin
                rx_rdy = 1'b1;
                if (read_vld) begin
                    remain_d = remain_q - 8'd1;
                    if (remain_q == 8'd1) rx_state_d = R_HDR;
                end
            end
            default: rx_state_d = R_HDR;
        endcase
    end

    // Round-robin search: walk distances NUM_CORES..1 so the nearest requester after last_grant wins.
    always_comb begin
        cand     = '0;
        pick     = '0;
        pick_vld = 1'b0;
        for (int k = NUM_CORES; k >= 1; k--) begin
            cand = {1'b0, last_grant_q} + 5'(k);
            if (cand >= NC) cand = cand - NC;
            for (int j = 0; j < NUM_CORES; j++)
                if (core_tx_vld[j] && cand == 5'(j)) begin
                    pick     = 4'(j);
                    pick_vld = 1'b1;
                end
        end
    end

    always_comb begin
        body_data = '0;
        body_vld  = 1'b0;
        body_last = 1'b0;
        for (int j = 0; j < NUM_CORES; j++)
            if (grant_q == 4'(j)) begin
                body_data = core_tx_data[8*j +: 8];
                body_vld  = core_tx_vld[j];
                body_last = core_tx_last[j];
            end
    end

    always_comb begin
        tx_state_d   = tx_state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        wr_vld       = 1'b0;
        wr_data      = '0;
        tx_rdy       = '0;
        case (tx_state_q)
            T_IDLE: begin
                if (pick_vld) begin
                    grant_d    = pick;
                    tx_state_d = T_HDR;
                end
            end
            T_HDR: begin
                wr_vld  = 1'b1;
                wr_data = {4'hA, grant_q};
                if (write_rdy) tx_state_d = T_BODY;
            end
            T_BODY: begin
                wr_vld  = body_vld;
                wr_data = body_data;
                for (int j = 0; j < NUM_CORES; j++)
                    tx_rdy[j] = write_rdy && (grant_q == 4'(j));
                if (body_vld && write_rdy && body_last) begin
                    last_grant_d = grant_q;
                    tx_state_d   = T_IDLE;
                end
            end
            default: tx_state_d = T_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            rx_state_q   <= R_HDR;
            sel_q        <= '0;
            remain_q     <= '0;
            drop_count_q <= '0;
            tx_state_q   <= T_IDLE;
            grant_q      <= '0;
            last_grant_q <= LAST_CORE;
        end else begin
            rx_state_q   <= rx_state_d;
            sel_q        <= sel_d;
            remain_q     <= remain_d;
            drop_count_q <= drop_count_d;
            tx_state_q   <= tx_state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Handshake outputs are forced quiet while reset is held, regardless of the pre-reset state.
    assign read_rdy     = rx_rdy & ~reset;
    assign core_rx_vld  = reset ? '0 : rx_vld;
    assign core_rx_data = {NUM_CORES{read_data}};
    assign write_vld    = wr_vld & ~reset;
    assign write_data   = reset ? 8'h00 : wr_data;
    assign core_tx_rdy  = reset ? '0 : tx_rdy;
    assign drop_count   = drop_count_q;
    assign led_busy     = ~reset & ((rx_state_q != R_HDR) | (tx_state_q != T_IDLE));
endmodule
